// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder4_speed.sv
// 4-bit carry-lookahead adder slice used once per nibble by serial_adder_ctrl.
// With SERIAL_ADDER_OVF_EN defined it also exports the carry into its MSB.
module fulladder4_speed
    import serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic                c_msb
`endif
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened to two logic levels instead of rippling.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[NIBBLE_W-1:0];
    assign cout = c[NIBBLE_W];

`ifdef SERIAL_ADDER_OVF_EN
    assign c_msb = c[NIBBLE_W-1];
`endif

endmodule

// File: rtl/serial_adder_ctrl.sv
// Add/subtract of WIDTH-bit operands, one nibble per cycle, behind valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the ovf_o signed-overflow output.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             op_sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic                accept;
    logic                last_nib;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic                nib_cmsb;
    logic                ovf_q;
`endif

    assign accept   = (state_q == IDLE) && req_valid_i;
    assign last_nib = (state_q == RUN) && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                nib_a = a_q[k*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    fulladder4_speed slice (
        .a     (nib_a),
        .b     (nib_b),
        .cin   (carry_q),
        .sum   (nib_sum),
        .cout  (nib_cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .c_msb (nib_cmsb)
`endif
    );

    // Subtract is a + ~b + 1, so the inversion and forced carry happen at capture time.
    // carry_q doubles as carry_o: after the last nibble it holds the final carry-out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= op_sub_i ? ~b_i : b_i;
            carry_q <= op_sub_i | carry_i;
        end else if (state_q == RUN) begin
            carry_q <= nib_cout;
            cnt_q   <= last_nib ? '0 : cnt_q + 1'b1;
            for (int k = 0; k < NIB; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    sum_q[k*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                end
            end
`ifdef SERIAL_ADDER_OVF_EN
            if (last_nib) begin
                ovf_q <= nib_cmsb ^ nib_cout;
            end
`endif
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=16 and WIDTH=4 instances).
// Expected results come from a behavioural model and are queued until the DUT responds.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         ovf;

    logic         req_valid4 = 1'b0;
    logic         req_ready4;
    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         resp_valid4;
    logic         resp_ready4 = 1'b0;
    logic [3:0]   sum4;
    logic         carry_out4;
    logic         ovf4;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_sub_i     (op_sub),
        .a_i          (a),
        .b_i          (b),
        .carry_i      (carry_in),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .sum_o        (sum),
        .carry_o      (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o        (ovf)
`endif
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid4),
        .req_ready_o  (req_ready4),
        .op_sub_i     (1'b0),
        .a_i          (a4),
        .b_i          (b4),
        .carry_i      (1'b0),
        .resp_valid_o (resp_valid4),
        .resp_ready_i (resp_ready4),
        .sum_o        (sum4),
        .carry_o      (carry_out4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o        (ovf4)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf4 = 1'b0;
`endif

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, queues the modelled result, then scrambles the operands
    // so that any late sampling of the inputs corrupts the result.
    task automatic applyStimulus(input logic sub, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic cin);
        logic [W-1:0] beff;
        logic [W:0]   full;
        exp_t         e;
        beff    = sub ? ~bv : bv;
        full    = {1'b0, av} + {1'b0, beff} + {{W{1'b0}}, (sub | cin)};
        e.sum   = full[W-1:0];
        e.carry = full[W];
        e.ovf   = (av[W-1] == beff[W-1]) && (full[W-1] != av[W-1]);
        exp_q.push_back(e);
        checkValue("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        op_sub    = sub;
        a         = av;
        b         = bv;
        carry_in  = cin;
        stepCycle();
        req_valid = 1'b0;
        op_sub    = 1'($urandom);
        a         = W'($urandom);
        b         = W'($urandom);
        carry_in  = 1'($urandom);
        checkValue("req_ready_busy", {31'b0, req_ready}, 32'd0);
    endtask

    // Waits for the response (called one cycle after the accept edge), checks latency
    // and result, optionally stalls the consumer for hold cycles, then completes it.
    task automatic checkOutput(input int hold);
        int   lat;
        exp_t e;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            stepCycle();
            lat++;
        end
        checkValue("latency", lat, NIB + 1);
        e = exp_q.pop_front();
        checkValue("sum", {16'b0, sum}, {16'b0, e.sum});
        checkValue("carry_out", {31'b0, carry_out}, {31'b0, e.carry});
`ifdef SERIAL_ADDER_OVF_EN
        checkValue("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                req_valid = 1'b1;
                a         = 16'h1234;
                b         = 16'h4321;
            end
            stepCycle();
            req_valid = 1'b0;
            checkValue("hold_valid", {31'b0, resp_valid}, 32'd1);
            checkValue("hold_ready", {31'b0, req_ready}, 32'd0);
            checkValue("hold_sum", {16'b0, sum}, {16'b0, e.sum});
            checkValue("hold_carry", {31'b0, carry_out}, {31'b0, e.carry});
`ifdef SERIAL_ADDER_OVF_EN
            checkValue("hold_ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
        end
        resp_ready = 1'b1;
        stepCycle();
        resp_ready = 1'b0;
        checkValue("post_valid", {31'b0, resp_valid}, 32'd0);
        checkValue("post_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        exp_t dropped;
        int   lat4;
        int   stray;

        $display("[TB] start");
        stepCycle();
        stepCycle();
        checkValue("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkValue("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkValue("rst_sum", {16'b0, sum}, 32'd0);
        checkValue("rst_carry", {31'b0, carry_out}, 32'd0);
        rst = 1'b0;
        stepCycle();

        applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0);
        checkOutput(0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b1);
        checkOutput(0);
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1);
        checkOutput(0);
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        checkOutput(0);
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0);
        checkOutput(0);
        applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0);
        checkOutput(10);

        // Reset while the third nibble is in flight must drop the operation silently.
        applyStimulus(1'b0, 16'hABCD, 16'h1111, 1'b0);
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        dropped = exp_q.pop_front();
        checkValue("abort_req_ready", {31'b0, req_ready}, 32'd1);
        checkValue("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkValue("abort_sum", {16'b0, sum}, 32'd0);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            if (resp_valid) stray++;
        end
        checkValue("abort_no_resp", stray, 0);
        applyStimulus(1'b0, 16'h1234, 16'h0F0F, 1'b1);
        checkOutput(0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
            checkOutput(i);
        end

        checkValue("w4_req_ready", {31'b0, req_ready4}, 32'd1);
        req_valid4 = 1'b1;
        a4         = 4'h9;
        b4         = 4'h8;
        stepCycle();
        req_valid4 = 1'b0;
        a4         = 4'h0;
        b4         = 4'h0;
        lat4       = 1;
        while (!resp_valid4 && lat4 < 20) begin
            stepCycle();
            lat4++;
        end
        checkValue("w4_latency", lat4, 2);
        checkValue("w4_sum", {28'b0, sum4}, 32'h1);
        checkValue("w4_carry", {31'b0, carry_out4}, 32'd1);
        resp_ready4 = 1'b1;
        stepCycle();
        resp_ready4 = 1'b0;
        checkValue("w4_post_ready", {31'b0, req_ready4}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
